axis_rx_frame_checker: RTL
==========================

Name: axis_rx_frame_checker

Overview:
Receive-side checker for the 100G Ethernet test path. It consumes the 512-bit AXI-Stream RX output of the CMAC (no backpressure) and checks each frame against the fixed test pattern produced by the TX generator: header, payload pattern, beat count, keep, and MAC error flag. It keeps saturating good, error and byte counters, plus sticky error flags, for ILA and VIO observation.

Parameters:
P_FRAME_BEATS, 10, expected number of 64-byte beats per frame (2..65535)
P_SRC_MAC, 48'h01_02_03_04_05_06, expected source MAC
P_DST_MAC, 48'hff_ff_ff_ff_ff_ff, expected destination MAC
P_TYPE, 16'h0800, expected EtherType
P_CNT_W, 32, width of statistics counters

Ports:
i_clk  in  1  CMAC RX user clock
i_rst  in  1  asynchronous reset, active-high
i_stat_rx_status  in  1  CMAC RX link/alignment status
i_clr  in  1  synchronous clear of counters and sticky flags
s_axis_rx_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed
s_axis_rx_tdata  in  512  beat data; first wire byte is in [7:0]
s_axis_rx_tlast  in  1  last beat of frame
s_axis_rx_tkeep  in  64  byte enables; bit i qualifies tdata[8i+:8]
s_axis_rx_tuser  in  1  MAC error, valid on the tlast beat
o_frame_ok  out  1  1-cycle pulse: frame passed all checks
o_frame_err  out  1  1-cycle pulse: frame failed at least one check
o_good_cnt  out  P_CNT_W  good frames counted
o_err_cnt  out  P_CNT_W  bad frames counted
o_byte_cnt  out  P_CNT_W  kept bytes received in all counted frames
o_hdr_err  out  1  sticky: header mismatch seen
o_data_err  out  1  sticky: payload mismatch or tkeep not all-ones
o_len_err  out  1  sticky: beat count not equal to P_FRAME_BEATS
o_mac_err  out  1  sticky: tuser was set on a tlast beat

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0.
- Internal byte reversal: chk[(63-i)*8+:8] = tdata[i*8+:8], so the first wire byte lands in chk[511:504]. All comparisons use chk.
- Expected data, per beat index k:
  - k=0: chk[511:400]=={P_DST_MAC,P_SRC_MAC,P_TYPE} (header check) and chk[399:0]=={50{8'hAB}}.
  - k=1: {32{16'hAABB}}.
  - k>=2: {32{k-1}}, where k-1 is truncated to 16 bits.
- Each valid beat must also have tkeep==64'hFFFF_FFFF_FFFF_FFFF, or data error.
- FSM states:
  - IDLE: ignore beats while i_stat_rx_status==0. On a valid beat with status 1 and tlast 0, evaluate beat 0, set beat counter to 1, go to BODY. A valid tlast beat in IDLE is a one-beat frame: evaluate it, flag len_err (P_FRAME_BEATS>=2), and stay in IDLE.
  - BODY: evaluate each valid beat at its index. On tlast, complete the frame and go to IDLE. If the counter reaches P_FRAME_BEATS and there is no tlast, set a length error and go to DROP.
  - DROP: discard beats without checking them. On tlast, complete the frame (error) and go to IDLE.
- Per-frame error accumulator: OR of header, data, length and tuser errors. It is cleared at the start of each frame.
- Completion: in the cycle after the tlast beat, pulse exactly one of o_frame_ok/o_frame_err. Increment the matching counter in that same cycle.
  - o_byte_cnt adds popcount(tkeep) for every beat of the frame. Accumulate it per frame and commit it at completion.
- Short frame (tlast at k < P_FRAME_BEATS-1) sets len_err. Long frame means no tlast by beat P_FRAME_BEATS-1.
- Counters saturate at all-ones and never wrap.
- Sticky flags set with the completion pulse of the failing frame and hold until i_clr or reset.
- If i_stat_rx_status falls mid-frame: abort to IDLE, no pulse, no counter change, partial bytes discarded.
- i_clr has priority over a same-cycle increment: counters become 0 and that increment is lost. The pulse still fires.
- Gaps (tvalid=0) within a frame are legal; state and beat index hold.

Test Plan:
1. Link up; one correct 10-beat frame matching the generator pattern -> one o_frame_ok pulse the cycle after tlast; good_cnt=1, err_cnt=0, byte_cnt=640, no flags.
2. 100 back-to-back correct frames with no idle gaps between them -> good_cnt=100, byte_cnt=64000, o_frame_err never asserts.
3. Corrupt byte 6 (src MAC MSB) of beat 0; separately beat 5 = {32{16'h0005}} instead of 0004 -> two err pulses, err_cnt=2, hdr_err=1, data_err=1.
4. 9-beat frame, then 12-beat frame -> err_cnt=2, len_err=1. The 12-beat frame's beats 10-11 are discarded in DROP; next correct frame counts as good.
5. tuser=1 on tlast of an otherwise good frame -> err pulse, mac_err=1. Then pulse i_clr -> all counters and flags 0.
6. Drop i_stat_rx_status after beat 4 and raise it 3 cycles later -> no pulse, counters unchanged. Assert i_rst mid-frame -> outputs 0, the next full frame is counted good.

Source files
------------

// File: rtl/axis_rx_frame_checker_if.sv
// AXI-Stream RX beat bundle from the CMAC user side (no tready: every valid beat is consumed).
interface axis_rx_frame_checker_if;
  logic         tvalid;
  logic [511:0] tdata;
  logic         tlast;
  logic [63:0]  tkeep;
  logic         tuser;

  modport master (output tvalid, tdata, tlast, tkeep, tuser);
  modport slave  (input  tvalid, tdata, tlast, tkeep, tuser);
endinterface

// File: rtl/axis_rx_frame_checker.sv
// Checks CMAC RX frames against the fixed TX generator pattern and keeps
// saturating good/error/byte counters plus sticky error flags.
module axis_rx_frame_checker #(
  parameter int          P_FRAME_BEATS = 10,
  parameter logic [47:0] P_SRC_MAC     = 48'h01_02_03_04_05_06,
  parameter logic [47:0] P_DST_MAC     = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [15:0] P_TYPE        = 16'h0800,
  parameter int          P_CNT_W       = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stat_rx_status,
  input  logic                       i_clr,
  axis_rx_frame_checker_if.slave     s_axis_rx,
  output logic                       o_frame_ok,
  output logic                       o_frame_err,
  output logic [P_CNT_W-1:0]         o_good_cnt,
  output logic [P_CNT_W-1:0]         o_err_cnt,
  output logic [P_CNT_W-1:0]         o_byte_cnt,
  output logic                       o_hdr_err,
  output logic                       o_data_err,
  output logic                       o_len_err,
  output logic                       o_mac_err
);

  localparam int              ACC_W    = 32;
  localparam int              ACC_W1   = ACC_W + 1;
  localparam int              SUM_W    = ((P_CNT_W > ACC_W) ? P_CNT_W : ACC_W) + 1;
  localparam logic [16:0]     LAST_IDX = 17'(P_FRAME_BEATS - 1);
  localparam logic [16:0]     N_BEATS  = 17'(P_FRAME_BEATS);
  localparam logic [111:0]    HDR      = {P_DST_MAC, P_SRC_MAC, P_TYPE};
  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DROP} state_t;

  state_t               state_q, state_d;
  logic [16:0]          beat_q, beat_d;
  logic                 f_hdr_q, f_hdr_d;
  logic                 f_data_q, f_data_d;
  logic                 f_len_q, f_len_d;
  logic [ACC_W-1:0]     bytes_q, bytes_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [P_CNT_W-1:0]   good_cnt_q, good_cnt_d;
  logic [P_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [P_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                 hdr_err_q, hdr_err_d;
  logic                 data_err_q, data_err_d;
  logic                 len_err_q, len_err_d;
  logic                 mac_err_q, mac_err_d;

  // First wire byte ends up in the most significant byte of chk.
  logic [511:0] chk;
  for (genvar gi = 0; gi < 64; gi++) begin : g_rev
    assign chk[(63-gi)*8 +: 8] = s_axis_rx.tdata[gi*8 +: 8];
  end

  logic [6:0]       pop;
  logic [15:0]      k16;
  logic             keep_bad;
  logic             b0_hdr_bad;
  logic             b0_data_bad;
  logic             body_data_bad;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;

  assign pop           = 7'($countones(s_axis_rx.tkeep));
  assign k16           = 16'(beat_q - 17'd1);
  assign keep_bad      = (s_axis_rx.tkeep != '1);
  assign b0_hdr_bad    = (chk[511:400] != HDR);
  assign b0_data_bad   = (chk[399:0] != {50{8'hAB}}) || keep_bad;
  assign body_data_bad = ((beat_q == 17'd1) ? (chk != {32{16'hAABB}})
                                            : (chk != {32{k16}})) || keep_bad;
  assign acc_sum       = {1'b0, bytes_q} + ACC_W1'(pop);
  assign acc_next      = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  logic             complete;
  logic             c_hdr, c_data, c_len, c_mac, c_bad;
  logic [ACC_W-1:0] c_bytes;
  logic [SUM_W-1:0] byte_sum;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    f_hdr_d    = f_hdr_q;
    f_data_d   = f_data_q;
    f_len_d    = f_len_q;
    bytes_d    = bytes_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    byte_cnt_d = byte_cnt_q;
    hdr_err_d  = hdr_err_q;
    data_err_d = data_err_q;
    len_err_d  = len_err_q;
    mac_err_d  = mac_err_q;
    complete   = 1'b0;
    c_hdr      = 1'b0;
    c_data     = 1'b0;
    c_len      = 1'b0;
    c_mac      = 1'b0;
    c_bytes    = '0;
    byte_sum   = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_stat_rx_status && s_axis_rx.tvalid) begin
          if (s_axis_rx.tlast) begin
            complete = 1'b1;
            c_hdr    = b0_hdr_bad;
            c_data   = b0_data_bad;
            c_len    = 1'b1;
            c_mac    = s_axis_rx.tuser;
            c_bytes  = ACC_W'(pop);
          end else begin
            state_d  = ST_BODY;
            beat_d   = 17'd1;
            f_hdr_d  = b0_hdr_bad;
            f_data_d = b0_data_bad;
            f_len_d  = 1'b0;
            bytes_d  = ACC_W'(pop);
          end
        end
      end
      ST_BODY: begin
        if (!i_stat_rx_status) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else if (s_axis_rx.tvalid) begin
          if (s_axis_rx.tlast) begin
            complete = 1'b1;
            c_hdr    = f_hdr_q;
            c_data   = f_data_q | body_data_bad;
            c_len    = f_len_q | (beat_q != LAST_IDX);
            c_mac    = s_axis_rx.tuser;
            c_bytes  = acc_next;
            state_d  = ST_IDLE;
            beat_d   = '0;
          end else begin
            f_data_d = f_data_q | body_data_bad;
            bytes_d  = acc_next;
            beat_d   = beat_q + 17'd1;
            // Final expected beat passed without tlast: the rest is unchecked.
            if (beat_q + 17'd1 == N_BEATS) begin
              f_len_d = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (!i_stat_rx_status) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else if (s_axis_rx.tvalid) begin
          bytes_d = acc_next;
          if (s_axis_rx.tlast) begin
            complete = 1'b1;
            c_hdr    = f_hdr_q;
            c_data   = f_data_q;
            c_len    = 1'b1;
            c_mac    = s_axis_rx.tuser;
            c_bytes  = acc_next;
            state_d  = ST_IDLE;
            beat_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase

    c_bad = c_hdr | c_data | c_len | c_mac;
    if (complete) begin
      ok_d  = ~c_bad;
      err_d = c_bad;
      if (c_bad) begin
        err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
      end else begin
        good_cnt_d = (good_cnt_q == CNT_MAX) ? good_cnt_q : good_cnt_q + 1'b1;
      end
      byte_sum   = SUM_W'(byte_cnt_q) + SUM_W'(c_bytes);
      byte_cnt_d = (byte_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : byte_sum[P_CNT_W-1:0];
      hdr_err_d  = hdr_err_q  | c_hdr;
      data_err_d = data_err_q | c_data;
      len_err_d  = len_err_q  | c_len;
      mac_err_d  = mac_err_q  | c_mac;
    end

    // Clear wins over a same-cycle update; the completion pulse is unaffected.
    if (i_clr) begin
      good_cnt_d = '0;
      err_cnt_d  = '0;
      byte_cnt_d = '0;
      hdr_err_d  = 1'b0;
      data_err_d = 1'b0;
      len_err_d  = 1'b0;
      mac_err_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      f_hdr_q    <= 1'b0;
      f_data_q   <= 1'b0;
      f_len_q    <= 1'b0;
      bytes_q    <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      byte_cnt_q <= '0;
      hdr_err_q  <= 1'b0;
      data_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      mac_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      f_hdr_q    <= f_hdr_d;
      f_data_q   <= f_data_d;
      f_len_q    <= f_len_d;
      bytes_q    <= bytes_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_err_q  <= hdr_err_d;
      data_err_q <= data_err_d;
      len_err_q  <= len_err_d;
      mac_err_q  <= mac_err_d;
    end
  end

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_good_cnt  = good_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_byte_cnt  = byte_cnt_q;
  assign o_hdr_err   = hdr_err_q;
  assign o_data_err  = data_err_q;
  assign o_len_err   = len_err_q;
  assign o_mac_err   = mac_err_q;

endmodule
